// File: rtl/safe_lock_pkg.sv
// Shared definitions for the safe-lock unlock path.
//   tx_state_t : state encoding of the serial unlock transmitter
//   *_DEF      : default code width, inter-bit gap and response timeout
package safe_lock_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    GAP       = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } tx_state_t;

  localparam int CODE_W_DEF     = 4;
  localparam int GAP_CYCLES_DEF = 1;
  localparam int TIMEOUT_DEF    = 8;

endpackage

// File: rtl/unlock_code_tx_if.sv
// Bundle of all handshake/serial/result signals of unlock_code_tx.
//   code_valid/code_data/code_ready : parallel code handshake
//   ser_val/ser_data                : serial bit stream to the lock
//   resp_val/resp_data              : lock's registered response
//   done/unlocked/timeout           : transaction result
// Modports:
//   slave  : the transmitter's view (unlock_code_tx)
//   master : the environment's view (code source + lock + result sink)
interface unlock_code_tx_if #(
  parameter int CODE_W = 4
);
  logic              code_valid;
  logic [CODE_W-1:0] code_data;
  logic              code_ready;
  logic              ser_val;
  logic              ser_data;
  logic              resp_val;
  logic              resp_data;
  logic              done;
  logic              unlocked;
  logic              timeout;

  modport slave (
    input  code_valid, code_data, resp_val, resp_data,
    output code_ready, ser_val, ser_data, done, unlocked, timeout
  );

  modport master (
    output code_valid, code_data, resp_val, resp_data,
    input  code_ready, ser_val, ser_data, done, unlocked, timeout
  );
endinterface

// File: rtl/unlock_code_tx.sv
// Serial unlock-code transmitter.
// Accepts a parallel code word (valid/ready), shifts it out MSB-first with
// one ser_val pulse per bit and GAP_CYCLES idle cycles between bits, then
// waits up to TIMEOUT cycles for the lock's response. A response arriving
// at any point while sending ends the transaction early.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : unlock_code_tx_if.slave (code handshake, serial out, lock
//          response in, done/unlocked/timeout result)
// Every output is a flop; nothing on the interface is combinationally
// derived from an input.
module unlock_code_tx
  import safe_lock_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rstn,
  unlock_code_tx_if.slave bus
);

  localparam int BW = $clog2(CODE_W + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BIT_LOAD = BW'(CODE_W);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [WW-1:0] WAIT_END = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  generate
    if (CODE_W < 1)     begin : g_bad_code_w  $error("CODE_W must be >= 1");     end
    if (GAP_CYCLES < 1) begin : g_bad_gap     $error("GAP_CYCLES must be >= 1"); end
    if (TIMEOUT < 1)    begin : g_bad_timeout $error("TIMEOUT must be >= 1");    end
  endgenerate

  tx_state_t         state;
  logic [CODE_W-1:0] sreg;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [WW-1:0]     wait_cnt;

  logic code_ready_q, ser_val_q, ser_data_q, done_q, unlocked_q, timeout_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      sreg         <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      wait_cnt     <= '0;
      code_ready_q <= 1'b1;
      ser_val_q    <= 1'b0;
      ser_data_q   <= 1'b0;
      done_q       <= 1'b0;
      unlocked_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // Pulsed outputs default low; the branch entering SEND/DONE raises them.
      ser_val_q  <= 1'b0;
      ser_data_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.code_valid) begin
            sreg         <= bus.code_data;
            bit_cnt      <= BIT_LOAD;
            unlocked_q   <= 1'b0;
            timeout_q    <= 1'b0;
            code_ready_q <= 1'b0;
            ser_val_q    <= 1'b1;
            ser_data_q   <= bus.code_data[CODE_W-1];
            state        <= SEND;
          end
        end

        SEND, GAP, WAIT_RESP: begin
          if (bus.resp_val) begin
            // Lock has answered and gone idle: drop any unsent bits.
            unlocked_q <= bus.resp_data;
            timeout_q  <= 1'b0;
            done_q     <= 1'b1;
            state      <= DONE;
          end else if (state == SEND) begin
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt - BIT_ONE;
            if (bit_cnt > BIT_ONE) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT_RESP;
            end
          end else if (state == GAP) begin
            gap_cnt <= gap_cnt - GAP_ONE;
            if (gap_cnt == GAP_ONE) begin
              ser_val_q  <= 1'b1;
              ser_data_q <= sreg[CODE_W-1];
              state      <= SEND;
            end
          end else begin
            if (wait_cnt == WAIT_END) begin
              timeout_q  <= 1'b1;
              unlocked_q <= 1'b0;
              done_q     <= 1'b1;
              state      <= DONE;
            end else begin
              wait_cnt <= wait_cnt + WAIT_ONE;
            end
          end
        end

        DONE: begin
          code_ready_q <= 1'b1;
          state        <= IDLE;
        end

        default: begin
          code_ready_q <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.code_ready = code_ready_q;
  assign bus.ser_val    = ser_val_q;
  assign bus.ser_data   = ser_data_q;
  assign bus.done       = done_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_unlock_code_tx.sv
// Self-checking bench for unlock_code_tx: directed scenarios followed by
// randomized transactions. A lock model answers a chosen number of cycles
// after a chosen bit; the expected per-cycle waveform is derived from the
// timing rules with plain arithmetic.
module tb_unlock_code_tx;

  localparam int W = 4;
  localparam int G = 1;
  localparam int T = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  unlock_code_tx_if #(.CODE_W(W)) bus ();

  unlock_code_tx #(.CODE_W(W), .GAP_CYCLES(G), .TIMEOUT(T)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ser_val, ser_data, done, unlocked, timeout, code_ready}
  function automatic logic [5:0] outs();
    return {bus.ser_val, bus.ser_data, bus.done, bus.unlocked, bus.timeout, bus.code_ready};
  endfunction

  function automatic int bitcyc(input int i);
    return 1 + i * (G + 1);
  endfunction

  // Caller is at a negedge of an IDLE cycle; that cycle is cycle 0.
  // k = bit after which the lock answers (0 = never), d = answer delay,
  // rv = answer value, hold = keep code_valid high throughout.
  task automatic run_txn(input logic [W-1:0] code, input int k, input int d,
                         input logic rv, input bit hold);
    int dc, r, nb, cd, seen, idx;
    logic exp_unl, exp_to, exp_sv, exp_sd;
    if (k == 0) begin
      dc = bitcyc(W - 1) + 1 + T;
      nb = W;
      exp_unl = 1'b0;
      exp_to  = 1'b1;
    end else begin
      r  = bitcyc(k - 1) + d;
      dc = r + 1;
      nb = 0;
      for (int i = 0; i < W; i++) if (bitcyc(i) <= r) nb++;
      exp_unl = rv;
      exp_to  = 1'b0;
    end
    chk("ready_c0", bus.code_ready, 1);
    bus.code_valid = 1'b1;
    bus.code_data  = code;
    seen = 0;
    cd   = 0;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if (!hold) bus.code_valid = 1'b0;
      if (cd == 1) begin
        bus.resp_val  = 1'b1;
        bus.resp_data = rv;
      end else if (c >= dc) begin
        // Stray responses in DONE/IDLE must be ignored.
        bus.resp_val  = 1'($urandom);
        bus.resp_data = 1'($urandom);
      end else begin
        bus.resp_val  = 1'b0;
        bus.resp_data = 1'($urandom);
      end
      if (cd > 0) cd--;
      exp_sv = 1'b0;
      exp_sd = 1'b0;
      if ((c - 1) % (G + 1) == 0) begin
        idx = (c - 1) / (G + 1);
        if (idx < nb) begin
          exp_sv = 1'b1;
          exp_sd = code[W-1-idx];
        end
      end
      chk($sformatf("cyc%0d", c), outs(),
          {exp_sv, exp_sd, c == dc, (c >= dc) ? exp_unl : 1'b0,
           (c >= dc) ? exp_to : 1'b0, c == dc + 1});
      if (bus.ser_val) begin
        seen++;
        if (k != 0 && seen == k) cd = d;
      end
    end
    chk("unlocked", bus.unlocked, exp_unl);
    chk("timeout", bus.timeout, exp_to);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.code_valid = 1'b0;
    bus.code_data  = '0;
    bus.resp_val   = 1'b0;
    bus.resp_data  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 6'b000001);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 6'b000001);

    // 1: full code, unlock after the last bit
    run_txn(4'b1011, 4, 1, 1'b1, 1'b0);
    // 2: reject after third bit
    run_txn(4'b1001, 3, 1, 1'b0, 1'b0);
    // 3: reject after first bit
    run_txn(4'b0110, 1, 1, 1'b0, 1'b0);
    // 4: no response at all
    run_txn(4'b1011, 0, 1, 1'b0, 1'b0);
    // response coinciding with the last timeout cycle
    run_txn(4'b0101, 4, T, 1'b1, 1'b0);
    // response landing in a SEND cycle
    run_txn(4'b1110, 2, 2, 1'b1, 1'b0);
    // 5: code_valid held through back-to-back transactions
    run_txn(4'b1100, 4, 1, 1'b1, 1'b1);
    run_txn(4'b0011, 2, 1, 1'b0, 1'b1);
    run_txn(4'b1111, 4, 1, 1'b1, 1'b0);

    // 6: reset in mid-GAP after a result of unlocked=1
    chk("pre_rst_unl", bus.unlocked, 1);
    bus.code_valid = 1'b1;
    bus.code_data  = 4'b1011;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.code_valid = 1'b0;
      bus.resp_val   = 1'b0;
    end
    @(negedge clk);
    chk("gap_before_rst", outs(), 6'b000000);
    rstn = 1'b0;
    #1;
    chk("rst_async", outs(), 6'b000001);
    @(negedge clk);
    chk("rst_held", outs(), 6'b000001);
    @(negedge clk);
    rstn = 1'b1;
    run_txn(4'b1011, 4, 1, 1'b1, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] code;
      int k, d;
      code = W'($urandom);
      k    = $urandom_range(W, 0);
      d    = (k == W) ? $urandom_range(T, 1) : $urandom_range(3, 1);
      run_txn(code, k, d, 1'($urandom), $urandom_range(3, 0) == 0);
    end

    bus.code_valid = 1'b0;
    bus.resp_val   = 1'b0;
    @(negedge clk);
    chk("final_idle", outs() & 6'b111001, 6'b000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/unlock_code_tx.md
Name: unlock_code_tx

Overview:
Serializing transmitter that drives the ser_val/ser_data serial unlock interface of the safe-lock mechanism. It accepts a parallel code word through a valid/ready handshake and shifts it out MSB-first, one bit per ser_val pulse, with idle gap cycles between bits. It then monitors the lock's registered response pair (output_val/output_data) and reports unlock, reject or timeout. It sits between the keypad/code-entry logic and the unlock mechanism.

Parameters:
CODE_W, 4, code word width in bits; must be >= 1.
GAP_CYCLES, 1, cycles with ser_val=0 after each non-final bit; must be >= 1 (elaboration-time check).
TIMEOUT, 8, WAIT_RESP cycles allowed before declaring a timeout; must be >= 1.

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
code_valid  input  1  code word offered
code_data  input  CODE_W  code word, MSB sent first
code_ready  output  1  high only in IDLE
ser_val  output  1  serial bit valid, to lock
ser_data  output  1  serial bit value, to lock
resp_val  input  1  lock response valid (lock's registered output_val)
resp_data  input  1  lock response value, 1 = unlock (lock's registered output_data)
done  output  1  one-cycle pulse when a transaction ends
unlocked  output  1  result: 1 = lock returned resp_data=1
timeout  output  1  result: no response within TIMEOUT cycles

Behaviour:
- Reset (async, immediate): state IDLE; ser_val=0, ser_data=0, done=0, unlocked=0, timeout=0, code_ready=1; shift register and counters cleared.
- FSM states: IDLE, SEND, GAP, WAIT_RESP, DONE. All outputs decode from flops only; no input-to-output combinational path.
- IDLE: code_ready=1. On code_valid&&code_ready at an edge: load the shift register with code_data, set bit_cnt=CODE_W, clear unlocked and timeout, go to SEND.
- SEND (exactly 1 cycle): ser_val=1, ser_data=shift register MSB. At the edge, shift left and decrement bit_cnt. If bits remain, go to GAP with gap_cnt=GAP_CYCLES; otherwise go to WAIT_RESP with wait_cnt=0.
- GAP: ser_val=0, ser_data=0. Decrement gap_cnt; go to SEND when the gap has lasted GAP_CYCLES cycles.
- WAIT_RESP: ser_val=0. Increment wait_cnt each cycle. When TIMEOUT cycles elapse with no response, set timeout=1 and unlocked=0, then go to DONE.
- Response (any of SEND, GAP, WAIT_RESP): resp_val=1 sampled at an edge latches unlocked<=resp_data and timeout<=0, then goes to DONE. Remaining bits are abandoned, because the lock has already returned to its idle state.
- If a response and the timeout coincide, the response wins.
- DONE (1 cycle): done=1, ser_val=0. Next state is IDLE. code_valid is ignored in DONE.
- unlocked and timeout hold their values until the next accepted code.
- resp_val while in IDLE or DONE is ignored.
- Latency, full code with GAP_CYCLES=G: the first bit is on the wire 1 cycle after acceptance. The bits span CODE_W + (CODE_W-1)*G cycles.
- Counter widths: $clog2(CODE_W+1), $clog2(GAP_CYCLES+1), $clog2(TIMEOUT+1). No wrap-around is possible.
- Reset mid-transaction: ser_val drops to 0 asynchronously and no partial result is reported. The lock is reset by the same rstn.

Decomposition:
- Shared package safe_lock_pkg: tx_state_t enum (IDLE, SEND, GAP, WAIT_RESP, DONE) and the default CODE_W/GAP_CYCLES/TIMEOUT constants.
- Single flat module; no sub-module is warranted.

Test Plan:
1. Defaults, code 4'b1011 accepted at cycle 0, bench lock model attached.
   - ser_val=1 in cycles 1, 3, 5, 7 with data 1, 0, 1, 1.
   - resp 1/1 in cycle 8; done=1 in cycle 9; unlocked=1, timeout=0.
2. Code 4'b1001.
   - Lock rejects after the third bit (resp_val=1, resp_data=0 in cycle 6).
   - The fourth bit is never driven; done in cycle 7; unlocked=0.
3. Code 4'b0110.
   - The first bit is rejected; resp in cycle 2.
   - done in cycle 3; unlocked=0; only one ser_val pulse is seen.
4. Code 4'b1011 with resp_val held 0.
   - WAIT_RESP lasts 8 cycles; done in cycle 16; timeout=1, unlocked=0.
5. code_valid held high through the whole transaction.
   - code_ready=0 from cycle 1 through DONE.
   - The second code is accepted only in the IDLE cycle after done.
6. rstn asserted in cycle 4 (mid-GAP), released in cycle 6.
   - All outputs are 0 immediately, with code_ready=1.
   - The next transaction then runs a clean full sequence.
